pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Parametrised pipeline hazard controller for the in-order core.
- Generalises the fixed 6-bit pause controller to NSTAGE stages (bit 0 = PC, bit NSTAGE-1 = wb).
- Adds per-stage flush with PC redirect, and a one-entry pending-redirect buffer so a flush raised under an older-stage stall is never lost.
- Adds saturating stall and flush performance counters.

Parameters:
- NSTAGE, 6, number of pipeline control points (PC, if, id, ex, mem, wb).
- ADDR_W, 32, redirect PC width.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- stall_req  in  NSTAGE  bit k: stage k requests stall (level, held while stalled)
- flush_req  in  NSTAGE  bit k: stage k resolves a redirect this cycle (single-cycle pulse; bit 0 unused)
- flush_pc  in  NSTAGE*ADDR_W  slice k: redirect target from stage k
- pause  out  NSTAGE  bit i: hold stage i register
- flush  out  NSTAGE  bit i: stage i register loads bubble
- redirect_valid  out  1  PC loads redirect_pc this cycle
- redirect_pc  out  ADDR_W  redirect target
- stall_cycles  out  CNT_W  cycles with pause != 0
- flush_count  out  CNT_W  redirects applied

Behaviour:
- Reset: synchronous, active-high.
  - While rst=1: pause, flush and redirect_valid are 0; redirect_pc = 0.
  - Next edge: pending_valid=0, pending_stage=0, pending_pc=0, both counters=0.
  - flush_req in a reset cycle is discarded.
- Stall: S = highest index with stall_req set. pause[i]=1 for i<=S, else 0. No request -> pause=0.
- Effective flush source F, combinational:
  - Candidates: pending entry (if pending_valid) and the highest set bit of flush_req.
  - Higher stage index wins; tie -> new flush_req wins (pending_pc replaced).
- Apply condition: F exists and no stall_req bit at index >= F.
- On apply:
  - flush[i]=1 for 1<=i<F.
  - pause[i]=0 for i<F: younger stalls are cancelled.
  - pause[i] for i>F follows the stall rule.
  - redirect_valid=1, redirect_pc = target of F.
  - Same cycle combinational; no added latency.
- Blocked (stall at index >= F):
  - Outputs follow the stall rule only; flush=0, redirect_valid=0.
  - Next edge: pending <- (F, target).
- Pending FSM:
  - IDLE -> PENDING when blocked.
  - PENDING -> IDLE on the edge after apply.
  - PENDING stays PENDING while blocked, updated only by an older-or-equal source.
  - A younger flush_req arriving while pending is dropped.
- Applied pending: consumed same edge (pending_valid<=0) unless a new blocked flush reloads it.
- stall_cycles: +1 per non-reset cycle with pause != 0. Saturates at all-ones.
- flush_count: +1 per cycle with redirect_valid=1. Saturates at all-ones.
- All outputs combinational from inputs and registers; only pending and counters are sequential.

Decomposition:
- Shared package pipe_pkg holds:
  - stage index constants (STG_PC=0, STG_IF=1, STG_ID=2, STG_EX=3, STG_MEM=4, STG_WB=5);
  - stage index type of width $clog2(NSTAGE).
- One natural sub-module: prio_msb (parametrised highest-set-bit encoder with valid flag). Instantiated for stall_req and flush_req.

Test Plan:
- NSTAGE=6: stall_req=000100 -> pause=000111, flush=0, redirect_valid=0, stall_cycles +1 per cycle.
- flush_req=001000, flush_pc[3]=0x1C000040, no stall -> flush=000110, redirect_valid=1, redirect_pc=0x1C000040, pause=0, flush_count=1.
- stall_req=000100 with flush_req=001000 -> flush=000110, pause=000000 (younger stall cancelled), redirect_valid=1.
- stall_req=010000 held 3 cycles; flush_req=001000 pulse at cycle 0 (pc 0x100):
  - cycles 0-2: pause=011111, redirect_valid=0;
  - stall drops at cycle 3: redirect_valid=1, redirect_pc=0x100, flush=000110;
  - cycle 4: pending clear.
- Same held stall; ex flush 0x100 at cycle 0, then wb flush (stage 5, 0x800) at cycle 1 -> wb applies immediately (no stall >=5), flush=011110, redirect_pc=0x800, pending cleared; later ex-pending never applies.
- rst asserted while PENDING with stall_cycles=7 -> next cycle pending_valid=0, both counters 0, outputs 0; flush_req during rst ignored.
- Counter saturation with CNT_W=4 -> stall_cycles holds 15 under continuous stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage indices, stage index type and pending-redirect FSM states
package pipe_pkg;
  localparam int STG_N   = 6;
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;
  typedef logic [$clog2(STG_N)-1:0] stage_t;
  typedef enum logic {IDLE, PENDING} pend_state_t;
endpackage

// File: rtl/pipe_ctrl_prio_msb.sv
// prio_msb: highest-set-bit encoder; ports: req in, valid/idx out
module prio_msb #(
  parameter int N = 6,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = req[i] ? W'(i) : idx;
  end
  assign valid = |req;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller; ins clk,rst,stall_req,flush_req,flush_pc; outs pause,flush,redirect_valid/pc,stall_cycles,flush_count
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGE = 6,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSTAGE-1:0]        stall_req,
  input  logic [NSTAGE-1:0]        flush_req,
  input  logic [NSTAGE*ADDR_W-1:0] flush_pc,
  output logic [NSTAGE-1:0]        pause,
  output logic [NSTAGE-1:0]        flush,
  output logic                     redirect_valid,
  output logic [ADDR_W-1:0]        redirect_pc,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         flush_count
);
  localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  pend_state_t       state;
  logic [IW-1:0]     pend_stage;
  logic [ADDR_W-1:0] pend_pc;
  logic              s_v, f_v, use_new, has_f, blocked, apply;
  logic [IW-1:0]     s_idx, f_idx, f_sel;
  logic [ADDR_W-1:0] tgt;
  logic [NSTAGE-1:0] smask;
  // the PC has no flush of its own, so bit 0 never names a source
  prio_msb #(.N(NSTAGE), .W(IW)) u_stall (.req(stall_req), .valid(s_v), .idx(s_idx));
  prio_msb #(.N(NSTAGE), .W(IW)) u_flush (.req({flush_req[NSTAGE-1:1], 1'b0}), .valid(f_v), .idx(f_idx));
  always_comb begin
    use_new = f_v && (state == IDLE || f_idx >= pend_stage);
    has_f   = f_v || state == PENDING;
    f_sel   = use_new ? f_idx : pend_stage;
    tgt     = use_new ? flush_pc[32'(f_idx)*ADDR_W +: ADDR_W] : pend_pc;
    blocked = !rst && has_f && s_v && s_idx >= f_sel;
    apply   = !rst && has_f && !blocked;
    for (int i = 0; i < NSTAGE; i++) begin
      smask[i] = !rst && s_v && IW'(i) <= s_idx;
      pause[i] = smask[i] && !(apply && IW'(i) < f_sel);
      flush[i] = apply && i >= STG_IF && IW'(i) < f_sel;
    end
    redirect_valid = apply;
    redirect_pc    = apply ? tgt : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pend_stage   <= '0;
      pend_pc      <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state        <= blocked ? PENDING : apply ? IDLE : state;
      pend_stage   <= blocked ? f_sel : pend_stage;
      pend_pc      <= blocked ? tgt : pend_pc;
      stall_cycles <= (|pause && ~&stall_cycles) ? stall_cycles + 1'b1 : stall_cycles;
      flush_count  <= (apply && ~&flush_count) ? flush_count + 1'b1 : flush_count;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl (NSTAGE=6, CNT_W=4)
module tb_pipe_ctrl;
  localparam int N = 6, AW = 32, CW = 4;
  typedef struct {
    logic [N-1:0]  p;
    logic [N-1:0]  f;
    logic          rv;
    logic [AW-1:0] rpc;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;
  logic clk = 0, rst = 1;
  logic [N-1:0]    stall_req = '0, flush_req = '0;
  logic [N*AW-1:0] flush_pc = '0;
  logic [N-1:0]    pause, flush;
  logic            redirect_valid;
  logic [AW-1:0]   redirect_pc;
  logic [CW-1:0]   stall_cycles, flush_count;
  exp_t            q[$];
  int              checks = 0, errors = 0;
  logic [CW-1:0]   m_sc = '0, m_fc = '0;
  pipe_ctrl #(.NSTAGE(N), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req), .flush_pc(flush_pc),
    .pause(pause), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic [N-1:0] st, input logic [N-1:0] fr, input logic [AW-1:0] pc,
                      input logic [N-1:0] ep, input logic [N-1:0] ef, input logic erv, input logic [AW-1:0] erpc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    stall_req = st;
    flush_req = fr;
    for (int k = 0; k < N; k++) flush_pc[k*AW +: AW] = fr[k] ? pc : 32'hDEAD_0000 + k;
    q.push_back('{p: ep, f: ef, rv: erv, rpc: erpc, sc: m_sc, fc: m_fc});
    if (r) begin
      m_sc = '0;
      m_fc = '0;
    end else begin
      if (ep != 0 && m_sc != '1) m_sc++;
      if (erv && m_fc != '1) m_fc++;
    end
    @(negedge clk);
    e = q.pop_front();
    chk("pause", 64'(pause), 64'(e.p));
    chk("flush", 64'(flush), 64'(e.f));
    chk("redirect_valid", 64'(redirect_valid), 64'(e.rv));
    chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
    chk("stall_cycles", 64'(stall_cycles), 64'(e.sc));
    chk("flush_count", 64'(flush_count), 64'(e.fc));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    m_sc = '0;
    m_fc = '0;
    step(1, 6'b000100, 6'b001000, 32'h55, 0, 0, 0, 0);
    repeat (3) step(0, 6'b000100, 0, 0, 6'b000111, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 6'b001000, 32'h1C000040, 0, 6'b000110, 1, 32'h1C000040);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 6'b000100, 6'b001000, 32'h2000, 0, 6'b000110, 1, 32'h2000);
    step(0, 6'b010000, 6'b001000, 32'h100, 6'b011111, 0, 0, 0);
    repeat (2) step(0, 6'b010000, 0, 0, 6'b011111, 0, 0, 0);
    step(0, 0, 0, 0, 0, 6'b000110, 1, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 6'b010000, 6'b001000, 32'h100, 6'b011111, 0, 0, 0);
    step(0, 6'b010000, 6'b100000, 32'h800, 0, 6'b011110, 1, 32'h800);
    step(0, 6'b010000, 0, 0, 6'b011111, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 6'b010000, 6'b010000, 32'h400, 6'b011111, 0, 0, 0);
    step(0, 6'b010000, 6'b001000, 32'h300, 6'b011111, 0, 0, 0);
    step(0, 6'b010000, 6'b010000, 32'h440, 6'b011111, 0, 0, 0);
    step(0, 0, 0, 0, 0, 6'b001110, 1, 32'h440);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 6'b010000, 6'b001000, 32'h900, 6'b011111, 0, 0, 0);
    step(1, 6'b010000, 6'b100000, 32'hA00, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (18) step(0, 6'b000001, 0, 0, 6'b000001, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
